current_decimator: RTL

CURRENT_DECIMATOR -- requirements
Module: current_decimator

---
 rtl/current_decimator_if.sv | 18 +
 rtl/current_decimator.sv | 125 ++++++++++++
 2 files changed

// File: rtl/current_decimator_if.sv
// Output stream of the current decimator: FIFO head word with valid/ready handshake.
interface current_decimator_if;
    logic [15:0] pDataOut;
    logic        pDataValid;
    logic        pDataReady;

    modport master (
        output pDataOut,
        output pDataValid,
        input  pDataReady
    );

    modport slave (
        input  pDataOut,
        input  pDataValid,
        output pDataReady
    );
endinterface

// File: rtl/current_decimator.sv
// Block-averaging decimator for a free-running current stream, buffered through a small FIFO
// with a sticky overflow flag.
module current_decimator #(
    parameter int unsigned DECIM_LOG2 = 4,
    parameter int unsigned SETTLE     = 24,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          pClk,
    input  logic                          pRst,
    input  logic [15:0]                   pDataIn,
    current_decimator_if.master           out_if,
    output logic                          pOverflow,
    output logic [$clog2(FIFO_DEPTH):0]   pFifoCount
);

    localparam int unsigned AccW  = 16 + DECIM_LOG2;
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned SetW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned SetLast = (SETTLE > 0) ? SETTLE - 1 : 0;

    typedef enum logic {StWarmup, StRun} state_e;

    // A zero settle time skips warmup entirely.
    localparam state_e StReset = (SETTLE == 0) ? StRun : StWarmup;

    state_e                state_q, state_d;
    logic [SetW-1:0]       settle_q, settle_d;
    logic [DECIM_LOG2-1:0] phase_q, phase_d;
    logic [AccW-1:0]       acc_q, acc_d;
    logic [AccW-1:0]       sum;
    logic                  push;
    logic [15:0]           push_data;

    logic [15:0]           mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]       wptr_q, wptr_d;
    logic [PtrW-1:0]       rptr_q, rptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  full, empty, pop, wr_en;

    // Decimation controller.
    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        phase_d   = phase_q;
        acc_d     = acc_q;
        push      = 1'b0;
        sum       = acc_q + AccW'(pDataIn);
        push_data = sum[AccW-1:DECIM_LOG2];
        unique case (state_q)
            StWarmup: begin
                if (settle_q == SetW'(SetLast)) begin
                    state_d  = StRun;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + SetW'(1);
                end
            end
            StRun: begin
                phase_d = phase_q + DECIM_LOG2'(1);
                acc_d   = (phase_q == '0) ? AccW'(pDataIn) : sum;
                push    = (phase_q == '1);
            end
            default: state_d = StReset;
        endcase
    end

    always_ff @(posedge pClk) begin
        if (!pRst) begin
            state_q  <= StReset;
            settle_q <= '0;
            phase_q  <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            phase_q  <= phase_d;
            acc_q    <= acc_d;
        end
    end

    // Output FIFO; a pop frees the slot a same-edge push needs when full.
    always_comb begin
        full    = (count_q == CntW'(FIFO_DEPTH));
        empty   = (count_q == '0);
        pop     = !empty && out_if.pDataReady;
        wr_en   = push && (!full || pop);
        wptr_d  = wr_en ? wptr_q + PtrW'(1) : wptr_q;
        rptr_d  = pop ? rptr_q + PtrW'(1) : rptr_q;
        count_d = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !wr_en) begin
            count_d = count_q - CntW'(1);
        end
        ovf_d   = ovf_q || (push && !wr_en);
    end

    always_ff @(posedge pClk) begin
        if (!pRst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge pClk) begin
        if (pRst && wr_en) begin
            mem_q[wptr_q] <= push_data;
        end
    end

    assign out_if.pDataOut   = mem_q[rptr_q];
    assign out_if.pDataValid = !empty;
    assign pOverflow         = ovf_q;
    assign pFifoCount        = count_q;

endmodule
